// File: rtl/regfile_pkg.sv
// Shared types and constants for the value-register write-back path.
// Used by wb_fifo2 and regfile_wb.
package regfile_pkg;

    localparam int DATA_W = 32;

    localparam logic [4:0] REG_V0 = 5'b10000;
    localparam logic [4:0] REG_V1 = 5'b10001;
    localparam logic [4:0] REG_V2 = 5'b10010;
    localparam logic [4:0] REG_V3 = 5'b10011;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_t;

    typedef struct packed {
        logic [4:0]        rd;
        logic [DATA_W-1:0] data;
    } wr_req_t;

endpackage

// File: rtl/wb_fifo2.sv
// Two-entry in-order FIFO for pending register writes.
// The occupancy FSM doubles as the count; slot0 is always the head.
module wb_fifo2
    import regfile_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  wr_req_t    push_req,
    input  logic       pop,
    output wr_req_t    head,
    output logic [1:0] count
);

    occ_t    state;
    occ_t    state_nx;
    wr_req_t slot0;
    wr_req_t slot1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        count    = 2'd0;
        case (state)
            EMPTY: begin
                count = 2'd0;
                if (push) state_nx = ONE;
            end
            ONE: begin
                count = 2'd1;
                if (push && !pop) state_nx = FULL;
                else if (!push && pop) state_nx = EMPTY;
            end
            FULL: begin
                count = 2'd2;
                if (pop) state_nx = ONE;
            end
            default: begin
                state_nx = EMPTY;
                count    = 2'd0;
            end
        endcase
    end

    // Push-with-pop in ONE replaces the head directly, so slot1 is never needed there.
    always_ff @(posedge clk) begin
        case (state)
            EMPTY: if (push) slot0 <= push_req;
            ONE: begin
                if (push && pop) slot0 <= push_req;
                else if (push) slot1 <= push_req;
            end
            FULL: if (pop) slot0 <= slot1;
            default: ;
        endcase
    end

    assign head = slot0;

endmodule

// File: rtl/regfile_wb.sv
// Write-back side of the v0-v3 register bank: buffers writes, commits in order.
// Optional feature macro: REGFILE_WB_ERRCNT_EN adds a saturating err_count output.
module regfile_wb
    import regfile_pkg::*;
#(
    parameter int         DEPTH = 2,
    parameter logic [4:0] BASE  = REG_V0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [4:0]        wr_rd,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              commit_en,
    output logic [DATA_W-1:0] v0,
    output logic [DATA_W-1:0] v1,
    output logic [DATA_W-1:0] v2,
    output logic [DATA_W-1:0] v3,
    output logic              busy,
    output logic              wr_err
`ifdef REGFILE_WB_ERRCNT_EN
    ,
    output logic [7:0]        err_count
`endif
);

    logic [1:0]        count;
    logic              push;
    logic              pop;
    wr_req_t           push_req;
    wr_req_t           head;
    logic [5:0]        offset;
    logic              legal;
    logic [DATA_W-1:0] vreg [4];

    assign wr_ready = (count != 2'(DEPTH));
    assign busy     = (count != 2'd0);
    assign push     = wr_valid && wr_ready;
    assign pop      = commit_en && busy;
    assign push_req = '{rd: wr_rd, data: wr_data};

    wb_fifo2 u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_req (push_req),
        .pop      (pop),
        .head     (head),
        .count    (count)
    );

    // Addresses below BASE wrap to large offsets, so one compare covers both bounds.
    assign offset = {1'b0, head.rd} - {1'b0, BASE};
    assign legal  = (offset < 6'd4);

    always_ff @(posedge clk) begin
        if (rst) begin
            vreg   <= '{default: '0};
            wr_err <= 1'b0;
        end else begin
            wr_err <= pop && !legal;
            if (pop && legal) vreg[offset[1:0]] <= head.data;
        end
    end

    assign v0 = vreg[0];
    assign v1 = vreg[1];
    assign v2 = vreg[2];
    assign v3 = vreg[3];

`ifdef REGFILE_WB_ERRCNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err_count <= '0;
        end else if (pop && !legal && err_count != '1) begin
            err_count <= err_count + 8'd1;
        end
    end
`endif

endmodule
